// File: rtl/linear_regression_seq.sv
// rtl/linear_regression_seq.sv - sequential price estimator y = intercept + slope * x
// Shift-add multiplier (one x bit per clock) with valid/ready handshakes and overflow detection.
module linear_regression_seq #(
  parameter int          IN_W      = 16,
  parameter int          COEF_W    = 16,
  parameter int          OUT_W     = 32,
  parameter bit          SAT_EN    = 1'b1,
  parameter int unsigned DEF_SLOPE = 5000,
  parameter int unsigned DEF_ICPT  = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_we,
  input  logic [COEF_W-1:0] coef_slope,
  input  logic [COEF_W-1:0] coef_icpt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  output logic              out_ovf,
  output logic              busy
);

  localparam int ACC_W = IN_W + COEF_W;
  localparam int SUM_W = ACC_W + 1;
  // Sum is evaluated at least one bit wider than OUT_W so the overflow slice always exists.
  localparam int EXT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W + 1;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [COEF_W-1:0] slope_q;
  logic [COEF_W-1:0] icpt_q;
  logic [IN_W-1:0]   x_sh;
  logic [ACC_W-1:0]  mcand;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  logic [EXT_W-1:0]  sum_ext;
  logic              ovf;
  logic [OUT_W-1:0]  y_next;

  assign in_ready = (state == IDLE) && !coef_we;
  assign busy     = (state != IDLE);

  always_comb begin
    sum_ext = EXT_W'(acc) + EXT_W'(icpt_q);
    ovf     = |sum_ext[EXT_W-1:OUT_W];
    y_next  = (SAT_EN && ovf) ? {OUT_W{1'b1}} : sum_ext[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slope_q   <= COEF_W'(DEF_SLOPE);
      icpt_q    <= COEF_W'(DEF_ICPT);
      x_sh      <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_we) begin
            slope_q <= coef_slope;
            icpt_q  <= coef_icpt;
          end else if (in_valid) begin
            x_sh  <= in_x;
            mcand <= ACC_W'(slope_q);
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          // mcand holds slope << cnt, advanced by one shift per bit instead of a barrel shifter.
          if (x_sh[0]) acc <= acc + mcand;
          x_sh  <= x_sh >> 1;
          mcand <= mcand << 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(IN_W - 1)) state <= ADD;
        end
        ADD: begin
          out_y     <= y_next;
          out_ovf   <= ovf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_regression_seq.sv
// tb/tb_linear_regression_seq.sv - scoreboard bench for linear_regression_seq
// Three instances (32-bit, 24-bit saturating, 24-bit truncating) share one stimulus stream.
module tb_linear_regression_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_we;
  logic [15:0] coef_slope, coef_icpt;
  logic        in_valid;
  logic [15:0] in_x;
  logic        out_ready;

  logic        rdy_a, va, ovf_a, busy_a;
  logic [31:0] y_a;
  logic        rdy_b, vb, ovf_b, busy_b;
  logic [23:0] y_b;
  logic        rdy_c, vc, ovf_c, busy_c;
  logic [23:0] y_c;

  always #5 clk = ~clk;

  linear_regression_seq u_dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_slope(coef_slope), .coef_icpt(coef_icpt),
    .in_valid(in_valid), .in_ready(rdy_a), .in_x(in_x), .out_valid(va), .out_ready(out_ready),
    .out_y(y_a), .out_ovf(ovf_a), .busy(busy_a)
  );

  linear_regression_seq #(.OUT_W(24), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_slope(coef_slope), .coef_icpt(coef_icpt),
    .in_valid(in_valid), .in_ready(rdy_b), .in_x(in_x), .out_valid(vb), .out_ready(out_ready),
    .out_y(y_b), .out_ovf(ovf_b), .busy(busy_b)
  );

  linear_regression_seq #(.OUT_W(24), .SAT_EN(1'b0)) u_trn (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_slope(coef_slope), .coef_icpt(coef_icpt),
    .in_valid(in_valid), .in_ready(rdy_c), .in_x(in_x), .out_valid(vc), .out_ready(out_ready),
    .out_y(y_c), .out_ovf(ovf_c), .busy(busy_c)
  );

  typedef struct {
    longint unsigned y;
    bit              ovf;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t ea, eb, ec;
  int   n_cmp = 0;
  int   n_bad = 0;
  longint unsigned m_slope = 5000;
  longint unsigned m_icpt  = 10000;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: exact product plus intercept, then clamp or wrap to the output width.
  function automatic exp_t model(input longint unsigned x, input longint unsigned s,
                                 input longint unsigned i, input int ow, input bit sat);
    longint unsigned full;
    longint unsigned lim;
    exp_t e;
    full  = x * s + i;
    lim   = 64'd1 << ow;
    e.ovf = (full >= lim);
    e.y   = sat ? (e.ovf ? lim - 1 : full) : full % lim;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && va && out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_result", va, 0);
      else begin
        ea = q_a.pop_front();
        chk("a_y", y_a, ea.y);
        chk("a_ovf", ovf_a, ea.ovf);
      end
    end
    if (!rst && vb && out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_result", vb, 0);
      else begin
        eb = q_b.pop_front();
        chk("b_y", y_b, eb.y);
        chk("b_ovf", ovf_b, eb.ovf);
      end
    end
    if (!rst && vc && out_ready) begin
      if (q_c.size() == 0) chk("c_unexpected_result", vc, 0);
      else begin
        ec = q_c.pop_front();
        chk("c_y", y_c, ec.y);
        chk("c_ovf", ovf_c, ec.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise(input bit pulse);
    if (pulse) begin
      in_valid   = 1'($urandom);
      coef_we    = 1'($urandom);
      coef_slope = 16'($urandom);
      coef_icpt  = 16'($urandom);
    end
  endtask

  task automatic write_coef(input logic [15:0] s, input logic [15:0] i);
    coef_we    = 1'b1;
    coef_slope = s;
    coef_icpt  = i;
    in_valid   = 1'b1;
    in_x       = 16'h1234;
    @(negedge clk);
    chk("coef_in_ready", rdy_a, 0);
    tick();
    coef_we  = 1'b0;
    in_valid = 1'b0;
    m_slope  = s;
    m_icpt   = i;
    @(negedge clk);
    chk("coef_no_accept_busy", busy_a, 0);
    tick();
  endtask

  task automatic do_op(input logic [15:0] x, input int hold, input bit pulse);
    int          lat;
    logic [31:0] y0;
    q_a.push_back(model(x, m_slope, m_icpt, 32, 1'b1));
    q_b.push_back(model(x, m_slope, m_icpt, 24, 1'b1));
    q_c.push_back(model(x, m_slope, m_icpt, 24, 1'b0));
    in_valid = 1'b1;
    in_x     = x;
    @(negedge clk);
    chk("accept_in_ready", rdy_a, 1);
    tick();
    in_valid = 1'b0;
    in_x     = 16'($urandom);
    lat      = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (va || lat >= 40) break;
      chk("busy_in_ready", rdy_a, 0);
      tick();
      drive_noise(pulse);
    end
    // out_valid rises at acceptance edge + 17, first seen at the 18th falling edge.
    chk("latency", lat, 18);
    y0 = y_a;
    for (int k = 0; k < hold; k++) begin
      tick();
      drive_noise(pulse);
      @(negedge clk);
      chk("hold_valid", va, 1);
      chk("hold_y_stable", y_a, y0);
      chk("hold_in_ready", rdy_a, 0);
    end
    tick();
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", va, 0);
    chk("post_in_ready", rdy_a, 1);
    tick();
  endtask

  task automatic reset_mid();
    in_valid = 1'b1;
    in_x     = 16'hBEEF;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mul8_busy", busy_a, 1);
    tick();
    rst     = 1'b0;
    m_slope = 5000;
    m_icpt  = 10000;
    @(negedge clk);
    chk("rst_valid", va, 0);
    chk("rst_in_ready", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("aborted_never_valid", va, 0);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    coef_we    = 1'b0;
    coef_slope = '0;
    coef_icpt  = '0;
    in_valid   = 1'b0;
    in_x       = '0;
    out_ready  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_in_ready", rdy_a, 1);
    chk("reset_out_valid", va, 0);
    chk("reset_out_y", y_a, 0);
    chk("reset_out_ovf", ovf_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_b_out_valid", vb, 0);
    chk("reset_c_out_y", y_c, 0);
    tick();
    rst = 1'b0;
    tick();

    do_op(16'd4, 0, 1'b0);
    write_coef(16'd3, 16'd7);
    do_op(16'd65535, 1, 1'b0);
    write_coef(16'd65535, 16'd65535);
    do_op(16'd65535, 2, 1'b0);
    write_coef(16'd20000, 16'd0);
    do_op(16'd1000, 0, 1'b0);

    write_coef(16'd11, 16'd13);
    do_op(16'($urandom), 10, 1'b1);
    do_op(16'($urandom), 0, 1'b0);

    write_coef(16'd9, 16'd1);
    reset_mid();
    do_op(16'd2, 0, 1'b0);
    do_op(16'd0, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 1) == 1) write_coef(16'($urandom), 16'($urandom));
      if (r == 3) write_coef(16'd0, 16'($urandom));
      do_op(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2) tick();
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    chk("queue_c_drained", q_c.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
